mem_port_arbiter: RTL and testbench

//  Shares the single processor memory port (proc_req/Add/mem_ready/valid/Rdata) between the

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_priority.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the processor memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/arb_priority.sv
// Fetch vs load/store selection: D first, unless D has already won MAX_DSTREAK
// consecutive grants while a fetch was waiting.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       gnt_evt,
  input  arb_owner_t gnt_owner,
  output logic       sel_valid,
  output arb_owner_t sel_owner
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak;

  // Counts only D grants made while a fetch was held off; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (idle && !i_req) begin
      streak <= '0;
    end else if (gnt_evt) begin
      if (gnt_owner == OWN_I) begin
        streak <= '0;
      end else if (i_req && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = i_req | d_req;
    sel_owner = OWN_I;
    if (d_req && !(i_req && (streak == STREAK_MAX))) begin
      sel_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D),
// one transaction at a time, with a watchdog for lost responses.
//
//  state     | meaning
//  IDLE      | no transaction; requests sampled and one owner selected
//  REQ       | proc_req driven, waiting for mem_ready
//  WAIT_RESP | request accepted, waiting for valid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int bits        = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [bits-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_valid,
  output logic [bits-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [bits-1:0] d_addr,
  input  logic [bits-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_valid,
  output logic [bits-1:0] d_rdata,
  output logic            proc_req,
  output logic [bits-1:0] Add,
  output logic            we,
  output logic [bits-1:0] Wdata,
  input  logic            mem_ready,
  input  logic            valid,
  input  logic [bits-1:0] Rdata,
  output logic            err
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  arb_state_t state, state_nxt;
  arb_owner_t owner, owner_nxt;
  logic [WW-1:0] wdog, wdog_nxt;

  logic            proc_req_nxt, we_nxt, err_nxt;
  logic [bits-1:0] add_nxt, wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic            i_gnt_nxt, d_gnt_nxt, i_valid_nxt, d_valid_nxt;
  logic            gnt_evt, sel_valid;
  arb_owner_t      sel_owner;

  arb_priority #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_priority (
    .clk      (clk),
    .rst      (rst),
    .idle     (state == IDLE),
    .i_req    (i_req),
    .d_req    (d_req),
    .gnt_evt  (gnt_evt),
    .gnt_owner(owner),
    .sel_valid(sel_valid),
    .sel_owner(sel_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_I;
      wdog     <= '0;
      proc_req <= 1'b0;
      Add      <= '0;
      we       <= 1'b0;
      Wdata    <= '0;
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_valid  <= 1'b0;
      d_valid  <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      wdog     <= wdog_nxt;
      proc_req <= proc_req_nxt;
      Add      <= add_nxt;
      we       <= we_nxt;
      Wdata    <= wdata_nxt;
      i_gnt    <= i_gnt_nxt;
      d_gnt    <= d_gnt_nxt;
      i_valid  <= i_valid_nxt;
      d_valid  <= d_valid_nxt;
      i_rdata  <= i_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    wdog_nxt     = '0;
    proc_req_nxt = proc_req;
    add_nxt      = Add;
    we_nxt       = we;
    wdata_nxt    = Wdata;
    i_gnt_nxt    = 1'b0;
    d_gnt_nxt    = 1'b0;
    i_valid_nxt  = 1'b0;
    d_valid_nxt  = 1'b0;
    i_rdata_nxt  = i_rdata;
    d_rdata_nxt  = d_rdata;
    err_nxt      = 1'b0;
    gnt_evt      = 1'b0;

    case (state)
      IDLE: begin
        if (sel_valid) begin
          owner_nxt    = sel_owner;
          proc_req_nxt = 1'b1;
          state_nxt    = REQ;
          if (sel_owner == OWN_D) begin
            add_nxt   = d_addr;
            we_nxt    = d_we;
            wdata_nxt = d_wdata;
          end else begin
            add_nxt   = i_addr;
            we_nxt    = 1'b0;
            wdata_nxt = '0;
          end
        end
      end

      REQ, WAIT_RESP: begin
        // Watchdog wins over a response arriving on the last allowed cycle.
        if (wdog == WDOG_LAST) begin
          proc_req_nxt = 1'b0;
          err_nxt      = 1'b1;
          state_nxt    = IDLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
          if (state == REQ && mem_ready) begin
            proc_req_nxt = 1'b0;
            gnt_evt      = 1'b1;
            i_gnt_nxt    = (owner == OWN_I);
            d_gnt_nxt    = (owner == OWN_D);
            state_nxt    = WAIT_RESP;
          end
          if ((state == WAIT_RESP || mem_ready) && valid) begin
            if (owner == OWN_D) begin
              d_valid_nxt = 1'b1;
              d_rdata_nxt = Rdata;
            end else begin
              i_valid_nxt = 1'b1;
              i_rdata_nxt = Rdata;
            end
            state_nxt = IDLE;
            wdog_nxt  = '0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, contention/timeout/reset
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int BITS = 32;
  localparam int MAXD = 4;
  localparam int TMO  = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [BITS-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, Rdata = '0;
  logic            mem_ready = 1'b0, valid = 1'b0;
  logic            i_gnt, i_valid, d_gnt, d_valid, proc_req, we, err;
  logic [BITS-1:0] i_rdata, d_rdata, Add, Wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.bits(BITS), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .proc_req(proc_req), .Add(Add), .we(we), .Wdata(Wdata),
    .mem_ready(mem_ready), .valid(valid), .Rdata(Rdata), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus the fairness counter.
  bit              m_busy = 0, m_acc = 0, m_is_d = 0;
  int              m_age = 0, m_streak = 0;
  logic            e_proc_req = 0, e_we = 0, e_err = 0;
  logic            e_i_gnt = 0, e_d_gnt = 0, e_i_valid = 0, e_d_valid = 0;
  logic [BITS-1:0] e_add = '0, e_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;

  always @(posedge clk) begin
    e_i_gnt = 0; e_d_gnt = 0; e_i_valid = 0; e_d_valid = 0; e_err = 0;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_age = 0; m_streak = 0;
      e_proc_req = 0; e_add = '0; e_we = 0; e_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
    end else if (!m_busy) begin
      if (!i_req) m_streak = 0;
      if (i_req || d_req) begin
        m_is_d = d_req && !(i_req && m_streak >= MAXD);
        m_busy = 1; m_acc = 0; m_age = 0;
        e_proc_req = 1;
        e_add   = m_is_d ? d_addr : i_addr;
        e_we    = m_is_d ? d_we : 1'b0;
        e_wdata = m_is_d ? d_wdata : '0;
      end
    end else if (m_age == TMO - 1) begin
      e_err = 1; e_proc_req = 0; m_busy = 0;
    end else begin
      m_age++;
      if (!m_acc && mem_ready) begin
        m_acc = 1; e_proc_req = 0;
        if (m_is_d) begin
          e_d_gnt = 1;
          if (i_req && m_streak < MAXD) m_streak++;
        end else begin
          e_i_gnt = 1;
          m_streak = 0;
        end
      end
      if (m_acc && valid) begin
        if (m_is_d) begin e_d_valid = 1; e_d_rdata = Rdata; end
        else begin e_i_valid = 1; e_i_rdata = Rdata; end
        m_busy = 0;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model proc_req", proc_req, e_proc_req);
      check("model Add", Add, e_add);
      check("model we", we, e_we);
      check("model Wdata", Wdata, e_wdata);
      check("model i_gnt", i_gnt, e_i_gnt);
      check("model d_gnt", d_gnt, e_d_gnt);
      check("model i_valid", i_valid, e_i_valid);
      check("model d_valid", d_valid, e_d_valid);
      check("model i_rdata", i_rdata, e_i_rdata);
      check("model d_rdata", d_rdata, e_d_rdata);
      check("model err", err, e_err);
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_dly;
    int          valid_dly;
    logic [31:0] exp_add;
    bit          exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    i_req = !v.is_d; d_req = v.is_d;
    i_addr = v.is_d ? '0 : v.addr;
    d_addr = v.is_d ? v.addr : '0;
    d_we = v.we; d_wdata = v.wdata;
    mem_ready = 0; valid = 0;
    @(negedge clk);
    check({tag, " proc_req"}, proc_req, 1);
    check({tag, " Add"}, Add, v.exp_add);
    check({tag, " we"}, we, v.exp_we);
    check({tag, " Wdata"}, Wdata, v.exp_wdata);
    repeat (v.ready_dly) @(negedge clk);
    mem_ready = 1;
    if (v.valid_dly == 0) begin valid = 1; Rdata = v.rdata; end
    @(negedge clk);
    mem_ready = 0; valid = 0; i_req = 0; d_req = 0;
    check({tag, " gnt"}, v.is_d ? d_gnt : i_gnt, 1);
    check({tag, " proc_req drop"}, proc_req, 0);
    if (v.valid_dly > 0) begin
      repeat (v.valid_dly - 1) @(negedge clk);
      valid = 1; Rdata = v.rdata;
      @(negedge clk);
      valid = 0;
    end
    check({tag, " valid"}, v.is_d ? d_valid : i_valid, 1);
    check({tag, " rdata"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[4];
    int order[$];
    int exp_order[7];
    int nd, cyc;
    bit saw_gnt;

    vecs[0] = '{0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, 32'h100, 0, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1, 1, 32'h40, 32'h12345678, 32'h0, 0, 1, 32'h40, 1, 32'h12345678, 32'h0};
    vecs[2] = '{1, 0, 32'h200, 32'hFFFF0000, 32'hCAFEF00D, 0, 0, 32'h200, 0, 32'hFFFF0000, 32'hCAFEF00D};
    vecs[3] = '{0, 0, 32'h104, 32'h0, 32'h55AA55AA, 2, 0, 32'h104, 0, 32'h0, 32'h55AA55AA};
    exp_order = '{1, 1, 1, 1, 0, 1, 1};

    repeat (2) @(negedge clk);
    check("reset proc_req", proc_req, 0);
    check("reset Add", Add, 0);
    check("reset err", err, 0);
    rst = 0;
    chk_en = 1;
    @(negedge clk);

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Contention with a memory that accepts and answers in the same cycle.
    i_req = 1; i_addr = 32'h180; d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = '0;
    mem_ready = 1; valid = 1; Rdata = 32'hA5A5A5A5;
    nd = 0;
    for (int c = 0; c < 60 && (i_req || d_req); c++) begin
      @(negedge clk);
      if (d_gnt) begin
        order.push_back(1); nd++;
        check("same-cycle d_valid with d_gnt", d_valid, 1);
        if (nd == 6) d_req = 0;
      end
      if (i_gnt) begin order.push_back(0); i_req = 0; end
    end
    mem_ready = 0; valid = 0; i_req = 0; d_req = 0;
    check("contention grant count", order.size(), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("contention grant %0d owner", k), (k < order.size()) ? order[k] : 9, exp_order[k]);
    @(negedge clk);

    // Watchdog: memory never accepts.
    i_req = 1; i_addr = 32'h300;
    cyc = 0; saw_gnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cyc++;
      if (i_gnt || d_gnt) saw_gnt = 1;
      if (err) break;
    end
    check("timeout err", err, 1);
    check("timeout latency", cyc, 65);
    check("timeout proc_req", proc_req, 0);
    check("timeout no gnt", saw_gnt, 0);
    i_req = 0; valid = 1; Rdata = 32'h11112222;
    repeat (2) begin
      @(negedge clk);
      check("stale i_valid", i_valid, 0);
      check("stale d_valid", d_valid, 0);
    end
    valid = 0;

    // Reset while waiting for the response.
    d_req = 1; d_we = 0; d_addr = 32'h500;
    @(negedge clk);
    mem_ready = 1;
    @(negedge clk);
    check("rst-seq d_gnt", d_gnt, 1);
    mem_ready = 0; d_req = 0; rst = 1;
    @(negedge clk);
    check("rst-seq proc_req", proc_req, 0);
    check("rst-seq Add", Add, 0);
    check("rst-seq i_rdata", i_rdata, 0);
    check("rst-seq d_rdata", d_rdata, 0);
    rst = 0; valid = 1; Rdata = 32'h77;
    @(negedge clk);
    check("rst-seq stale d_valid", d_valid, 0);
    check("rst-seq stale d_rdata", d_rdata, 0);
    valid = 0;

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) rst = 0;
      else if ($urandom_range(0, 599) == 0) rst = 1;
      if (i_req && i_gnt) i_req = 0;
      if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1; i_addr = $urandom; end
      if (d_req && d_gnt) d_req = 0;
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      valid     = ($urandom_range(0, 2) == 0);
      Rdata     = $urandom;
    end
    @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
